// File: rtl/custom_vector_collector_pkg.sv
// Shared types and sizing helpers for the serial-to-vector collector.
package custom_vector_collector_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to count 0..n inclusive.
    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/custom_vector_collector_slot_counter.sv
// Slot index counter for the collector: increment with wrap at the last slot,
// load-to-1 for the "element taken while vector leaves" case, and clear.
module vector_slot_counter
    import custom_vector_collector_pkg::*;
#(
    parameter int NUM_INPUTS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_inc,
    input  logic                            i_load1,
    input  logic                            i_clr,
    output logic [CNT_W(NUM_INPUTS)-1:0]    o_cnt,
    output logic                            o_last
);

    localparam int CW = CNT_W(NUM_INPUTS);

    logic [CW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CW'(NUM_INPUTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            // A single-slot vector never has a partially filled state.
            r_cnt <= (NUM_INPUTS > 1) ? CW'(1) : '0;
        end else if (i_inc) begin
            r_cnt <= o_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/custom_vector_collector.sv
// Packs NUM_INPUTS serial elements into one vector for custom_vector_adder.
// Optional running sum on out_sum when CUSTOM_VECTOR_COLLECTOR_SUM_EN is defined.
module custom_vector_collector
    import custom_vector_collector_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int INPUT_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_vld,
    output logic                                in_rdy,
    input  logic [INPUT_WIDTH-1:0]              in_data,
    input  logic                                in_flush,
    output logic                                out_vld,
    input  logic                                out_rdy,
    output logic [NUM_INPUTS*INPUT_WIDTH-1:0]   out_vector,
    output logic [CNT_W(NUM_INPUTS)-1:0]        fill_cnt
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
    ,
    output logic [INPUT_WIDTH-1:0]              out_sum
`endif
);

    localparam int CW = CNT_W(NUM_INPUTS);

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] r_slots;
    logic [CW-1:0]                          w_cnt;
    logic                                   w_last;
    logic                                   w_hs_in;
    logic                                   w_hs_out;
    logic                                   w_wr_en;
    logic                                   w_cnt_inc;
    logic                                   w_cnt_load1;
    logic                                   w_cnt_clr;

    // in_rdy is held low during reset so nothing is accepted mid-reset.
    assign out_vld  = (r_state == HOLD);
    assign in_rdy   = !rst && (!out_vld || out_rdy);
    assign w_hs_in  = in_vld && in_rdy;
    assign w_hs_out = out_vld && out_rdy;

    assign out_vector = r_slots;
    assign fill_cnt   = w_cnt;

    vector_slot_counter #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_cnt_inc),
        .i_load1 (w_cnt_load1),
        .i_clr   (w_cnt_clr),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_load1 = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            FILL: begin
                // Flush beats a coincident element; the element is dropped.
                if (in_flush) begin
                    w_cnt_clr = 1'b1;
                end else if (w_hs_in) begin
                    w_wr_en   = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (w_last) w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_hs_out) begin
                    if (w_hs_in) begin
                        w_wr_en = 1'b1;
                        if (NUM_INPUTS == 1) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_state_nxt = FILL;
                            w_cnt_load1 = 1'b1;
                        end
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // The counter is 0 throughout HOLD, so w_cnt also addresses slot 0 there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slots <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (w_wr_en && (w_cnt == CW'(i))) r_slots[i] <= in_data;
            end
        end
    end

`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
    logic [INPUT_WIDTH-1:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (r_state == FILL && in_flush) begin
            r_sum <= '0;
        end else if (w_wr_en) begin
            r_sum <= (w_cnt == '0) ? in_data : r_sum + in_data;
        end
    end

    assign out_sum = r_sum;
`endif

endmodule

// File: tb/tb_custom_vector_collector.sv
// Bench for custom_vector_collector: queue-based model checked every cycle plus literal checks.
module tb_custom_vector_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_flush = 1'b0;
    logic        out_rdy = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_rdy;
    logic        out_vld;
    logic [63:0] out_vector;
    logic [3:0]  fill_cnt;

    logic        b_in_vld = 1'b0;
    logic [3:0]  b_in_data = 4'h0;
    logic        b_in_flush = 1'b0;
    logic        b_out_rdy = 1'b1;
    logic        b_in_rdy;
    logic        b_out_vld;
    logic [3:0]  b_out_vector;
    logic [0:0]  b_fill_cnt;
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
    logic [7:0]  out_sum;
    logic [3:0]  b_out_sum;
    logic [7:0]  m_sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: elements gathered so far, and the vector currently offered.
    logic [7:0]  m_buf[$];
    logic        m_vld = 1'b0;
    logic [63:0] m_vec = '0;

    always #5 clk = ~clk;

    custom_vector_collector #(.NUM_INPUTS(8), .INPUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_flush(in_flush), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_vector(out_vector), .fill_cnt(fill_cnt)
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
        , .out_sum(out_sum)
`endif
    );

    custom_vector_collector #(.NUM_INPUTS(1), .INPUT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_data(b_in_data),
        .in_flush(b_in_flush), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
        .out_vector(b_out_vector), .fill_cnt(b_fill_cnt)
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
        , .out_sum(b_out_sum)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the handshake rules for the edge that just happened.
    task automatic model_step();
        logic hs_in;
        logic hs_out;
        hs_in  = in_vld && (!m_vld || out_rdy);
        hs_out = m_vld && out_rdy;
        if (m_vld) begin
            if (hs_out) begin
                m_vld = 1'b0;
                if (hs_in) m_buf.push_back(in_data);
            end
        end else if (in_flush) begin
            m_buf.delete();
        end else if (hs_in) begin
            m_buf.push_back(in_data);
        end
        if (m_buf.size() == 8) begin
            m_vec = '0;
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
            m_sum = 8'h00;
`endif
            for (int i = 0; i < 8; i++) begin
                m_vec[i*8 +: 8] = m_buf[i];
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
                m_sum = m_sum + m_buf[i];
`endif
            end
            m_vld = 1'b1;
            m_buf.delete();
        end
    endtask

    // Inputs only change at negedge+1, so at negedge they still show what the last posedge saw.
    always @(negedge clk) begin
        if (rst) begin
            m_buf.delete();
            m_vld = 1'b0;
            chk("rst_in_rdy", 64'(in_rdy), 64'd0);
            chk("rst_out_vld", 64'(out_vld), 64'd0);
            chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        end else begin
            model_step();
            chk("in_rdy", 64'(in_rdy), 64'(!m_vld || out_rdy));
            chk("out_vld", 64'(out_vld), 64'(m_vld));
            chk("fill_cnt", 64'(fill_cnt), 64'(m_buf.size()));
            if (m_vld) begin
                chk("out_vector", out_vector, m_vec);
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
                chk("out_sum", 64'(out_sum), 64'(m_sum));
`endif
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_vld  = 1'b1;
        in_data = d;
        cyc();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset_out_vld", 64'(out_vld), 64'd0);
        chk("reset_out_vector", out_vector, 64'd0);
        chk("reset_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("reset_in_rdy", 64'(in_rdy), 64'd0);
        cyc();
        rst = 1'b0;
        #1 chk("release_in_rdy", 64'(in_rdy), 64'd1);

        // Basic fill
        out_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        in_vld = 1'b0;
        chk("basic_vld", 64'(out_vld), 64'd1);
        chk("basic_vector", out_vector, 64'h0807060504030201);
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
        chk("basic_sum", 64'(out_sum), 64'h24);
`endif
        cyc();
        chk("basic_vld_one_cycle", 64'(out_vld), 64'd0);

        // Backpressure
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
        in_vld  = 1'b1;
        in_data = 8'h99;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_rdy", 64'(in_rdy), 64'd0);
            chk("stall_vld", 64'(out_vld), 64'd1);
            chk("stall_vector", out_vector, 64'h1817161514131211);
            cyc();
        end
        out_rdy = 1'b1;
        #1 chk("release_in_rdy_hold", 64'(in_rdy), 64'd1);
        cyc();
        in_vld = 1'b0;
        chk("ninth_fill_cnt", 64'(fill_cnt), 64'd1);
        chk("ninth_vld", 64'(out_vld), 64'd0);
        in_flush = 1'b1;
        cyc();
        in_flush = 1'b0;
        chk("clear_fill_cnt", 64'(fill_cnt), 64'd0);

        // Flush
        for (int i = 1; i <= 3; i++) send(8'(i));
        chk("pre_flush_cnt", 64'(fill_cnt), 64'd3);
        in_vld   = 1'b1;
        in_data  = 8'h04;
        in_flush = 1'b1;
        #1 chk("flush_in_rdy", 64'(in_rdy), 64'd1);
        cyc();
        in_flush = 1'b0;
        in_vld   = 1'b0;
        chk("flush_fill_cnt", 64'(fill_cnt), 64'd0);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        in_vld = 1'b0;
        chk("flush_vld", 64'(out_vld), 64'd1);
        chk("flush_vector", out_vector, 64'hA7A6A5A4A3A2A1A0);
        cyc();

        // Modular wrap
        for (int i = 0; i < 8; i++) send(8'hFF);
        in_vld = 1'b0;
        chk("wrap_vector", out_vector, 64'hFFFFFFFFFFFFFFFF);
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
        chk("wrap_sum", 64'(out_sum), 64'hF8);
`endif
        cyc();

        // Async reset mid-fill
        for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
        in_vld = 1'b0;
        chk("mid_fill_cnt", 64'(fill_cnt), 64'd5);
        #1 rst = 1'b1;
        #1;
        chk("arst_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("arst_vector", out_vector, 64'd0);
        chk("arst_in_rdy", 64'(in_rdy), 64'd0);
        cyc();
        rst = 1'b0;
        #1 chk("arst_release_in_rdy", 64'(in_rdy), 64'd1);

        // Async reset in HOLD
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h41 + 8'(i));
        in_vld = 1'b0;
        chk("hold_vld", 64'(out_vld), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_hold_vld", 64'(out_vld), 64'd0);
        chk("arst_hold_vector", out_vector, 64'd0);
        cyc();
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h51 + 8'(i));
        in_vld = 1'b0;
        chk("post_rst_vld", 64'(out_vld), 64'd1);
        chk("post_rst_vector", out_vector, 64'h5857565554535251);
        cyc();

        // NUM_INPUTS = 1
        b_in_vld  = 1'b1;
        b_in_data = 4'h1;
        cyc();
        chk("n1_vld_1", 64'(b_out_vld), 64'd1);
        chk("n1_vec_1", 64'(b_out_vector), 64'h1);
        chk("n1_in_rdy", 64'(b_in_rdy), 64'd1);
        chk("n1_fill_cnt", 64'(b_fill_cnt), 64'd0);
        b_in_data = 4'h2;
        cyc();
        chk("n1_vld_2", 64'(b_out_vld), 64'd1);
        chk("n1_vec_2", 64'(b_out_vector), 64'h2);
        b_in_data = 4'h3;
        cyc();
        chk("n1_vld_3", 64'(b_out_vld), 64'd1);
        chk("n1_vec_3", 64'(b_out_vector), 64'h3);
`ifdef CUSTOM_VECTOR_COLLECTOR_SUM_EN
        chk("n1_sum_3", 64'(b_out_sum), 64'h3);
`endif
        b_in_vld = 1'b0;
        cyc();
        chk("n1_drain", 64'(b_out_vld), 64'd0);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/custom_vector_collector.md
# custom_vector_collector

Streaming deserializer that feeds `custom_vector_adder`. It accepts `INPUT_WIDTH`-bit elements one at a time over a valid/ready handshake and packs `NUM_INPUTS` of them into one vector. It then presents the vector over a second valid/ready handshake, in the same layout the adder consumes: element i occupies bits `[i*INPUT_WIDTH +: INPUT_WIDTH]`. It sits between any serial element source and the combinational adder.

## Interface
- `NUM_INPUTS`, default 8: elements per vector; legal range ≥ 1.
- `INPUT_WIDTH`, default 8: bits per element; legal range ≥ 1.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_vld`  input  1  source has an element on `in_data`.
- `in_rdy`  output  1  collector accepts an element this cycle.
- `in_data`  input  INPUT_WIDTH  element value.
- `in_flush`  input  1  single-cycle pulse that discards a partially filled vector.
- `out_vld`  output  1  `out_vector` holds a complete vector.
- `out_rdy`  input  1  sink takes the vector this cycle.
- `out_vector`  output  NUM_INPUTS*INPUT_WIDTH  packed vector, connects to the adder's `inst_INPUT`.
- `fill_cnt`  output  clog2(NUM_INPUTS+1)  number of slots written in the vector currently being built.
- `out_sum`  output  INPUT_WIDTH  present only with `CUSTOM_VECTOR_COLLECTOR_SUM_EN`; see Configuration.

## Operation
- Two states, FILL and HOLD. Reset state is FILL.
- An input handshake is `in_vld & in_rdy`. An output handshake is `out_vld & out_rdy`.
- **FILL**
  - `in_rdy` = 1 and `out_vld` = 0.
  - Each input handshake writes `in_data` to slot `fill_cnt`, then increments `fill_cnt`.
  - A handshake on slot `NUM_INPUTS-1` moves the block to HOLD and sets `fill_cnt` to 0.
- **HOLD**
  - `out_vld` = 1, and `out_vector` is held stable.
  - `in_rdy` = `out_rdy`, so an element can be taken in the same cycle the vector leaves.
  - An output handshake with no input handshake returns the block to FILL with `fill_cnt` = 0.
  - An output handshake together with an input handshake writes that element to slot 0. The block goes to FILL with `fill_cnt` = 1. If `NUM_INPUTS` = 1, the block stays in HOLD with the new vector instead.
- **Flush**
  - In FILL, `in_flush` sets `fill_cnt` to 0.
  - If `in_flush` coincides with an input handshake, the flush wins and the element is dropped. `in_rdy` is still 1 that cycle.
  - In HOLD, `in_flush` is ignored; a completed vector is never discarded.
- **Slot contents**
  - Slot registers are not cleared on output handshake or flush.
  - Every slot is rewritten before `out_vld` rises again, so stale contents are never visible.
- **Protocol**
  - `in_data` is sampled only on an input handshake.
  - Once asserted, `out_vld` stays high until the output handshake.
  - `in_rdy` depends combinationally on `out_rdy` only in HOLD.
  - No other combinational input-to-output paths exist.

## Timing
- Reset values: `out_vld` = 0, `out_vector` = 0, `fill_cnt` = 0, `out_sum` = 0. `in_rdy` = 0 while `rst` is high and 1 in the first cycle after release.
- Reset asserted mid-vector or during HOLD drops all partial or held data immediately.
- Latency: `out_vld` rises in the cycle after the edge that accepts the last element.
- Peak throughput is one element per cycle. With `out_rdy` tied high, a new vector appears every `NUM_INPUTS` cycles with no bubble.

## Configuration
- `CUSTOM_VECTOR_COLLECTOR_SUM_EN` defined:
  - Adds a running-sum register and the `out_sum` port.
  - The register loads `in_data` on a slot-0 write and adds `in_data`, modulo 2^INPUT_WIDTH, on every other slot write.
  - A flush resets it to 0.
  - While `out_vld` is high, `out_sum` equals the `SUM_inst` the adder produces for `out_vector`, and is used for self-checking.
- Undefined: no `out_sum` port and no sum register; all other behaviour is identical.

## Structure
- Package `custom_vector_collector_pkg` holds:
  - the state enum {FILL, HOLD};
  - a `CNT_W(n)` function returning clog2(n+1), used for the `fill_cnt` width.
- One natural sub-module, `vector_slot_counter`. It is the `fill_cnt` counter with increment, wrap at `NUM_INPUTS-1`, load-to-1 and clear inputs, and a last-slot flag output.
- The slot registers and the FSM stay in the top module.

## Test plan
- **Basic fill.** Defaults, `out_rdy` = 1, feed 1..8 back-to-back.
  - `out_vector` = 64'h0807060504030201, `out_vld` high for exactly 1 cycle.
  - With the macro, `out_sum` = 8'h24.
- **Backpressure.** Fill a vector with `out_rdy` = 0 for 5 cycles, then 1.
  - `in_rdy` = 0 and `out_vector` stable throughout the stall.
  - A 9th element offered on the release cycle is accepted into slot 0, and `fill_cnt` = 1 next cycle.
- **Flush.** Feed 3 elements, pulse `in_flush` together with a 4th, then feed 8'hA0..8'hA7.
  - `fill_cnt` goes to 0 after the flush.
  - The output vector contains only 8'hA0..8'hA7.
- **Modular wrap.** Macro defined, feed eight 8'hFF.
  - `out_sum` = 8'hF8, matching a reference `custom_vector_adder` instance on `out_vector`.
- **Async reset.** Assert `rst` mid-fill after 5 elements and again during HOLD.
  - Outputs go to their reset values without waiting for a clock edge.
  - The next 8 elements produce a clean vector.
- **NUM_INPUTS = 1.** `INPUT_WIDTH` = 4, `out_rdy` = 1, continuous `in_vld` with 1, 2, 3.
  - `out_vector` sequence 1, 2, 3 on consecutive cycles after the first acceptance.
  - `out_vld` held high continuously.
